timer: RTL and testbench
========================

Name: timer

Overview:
- Free-running LED blink timer: divides the system clock down to a square wave at BLINK_FREQ Hz on `led`.
- Pure leaf block: one clock domain, no handshakes, no external enable.
- Instanced at top level to drive a board LED. Also used as a liveness indicator.

Parameters:
- CLOCK_FREQ, default 100_000_000: input clock frequency in Hz; positive integer.
- BLINK_FREQ, default 1: output square-wave frequency in Hz; positive integer.
- HALF_PERIOD (derived localparam, not overridable): CLOCK_FREQ / (2*BLINK_FREQ). Integer division, truncating.
- CNT_W (derived localparam): max(1, $clog2(HALF_PERIOD)).

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- led, output, 1: blink output; registered, glitch-free.
- tick, output, 1: present only when TIMER_TICK_EN is defined; see Optional Feature.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset (rst=1 at a rising edge): cnt <= 0, led <= 0 (and tick <= 0 when enabled). The reset holds for as long as rst stays high.
- Run (rst=0 at a rising edge), if cnt == HALF_PERIOD-1: cnt <= 0 and led <= ~led.
- Run, otherwise: cnt <= cnt + 1.
- Latency: the first led toggle happens on the HALF_PERIOD-th rising edge at which rst is sampled low. Subsequent toggles occur every HALF_PERIOD cycles.
- Output period is exactly 2*HALF_PERIOD clk cycles with 50% duty cycle.
- Example: CLOCK_FREQ=100, BLINK_FREQ=2 gives HALF_PERIOD=25 and a 50-cycle period.
- Reset mid-count: the count is discarded and led returns to 0 on the next edge. After release the timing restarts from zero with no partial period.
- HALF_PERIOD == 1: led toggles on every enabled edge, so the output is clk/2. cnt stays 0.
- Parameter legality is enforced at elaboration via a generate-time $error: BLINK_FREQ > 0, CLOCK_FREQ > 0, CLOCK_FREQ >= 2*BLINK_FREQ (so HALF_PERIOD >= 1).
- Truncation from non-integer ratios is allowed, with no rounding. The effective frequency is then CLOCK_FREQ/(2*HALF_PERIOD).
- cnt never exceeds HALF_PERIOD-1; the wrap comparison uses the full CNT_W width.
- No combinational path from any input to led.

Optional Feature:
- Macro: TIMER_TICK_EN.
- When defined: output port `tick` is added. It is a registered 1-cycle pulse, high in exactly the cycle following each edge on which led toggles, i.e. aligned with the new led value. It is 0 during and immediately after reset.
- When undefined: no tick port and no extra logic. The led/cnt behaviour is identical in both builds.

Decomposition:
- Package timer_pkg holds:
  - function half_period(clock_freq, blink_freq);
  - function cnt_width(n), which returns max(1, $clog2(n));
  - constant DEFAULT_CLOCK_FREQ = 100_000_000.
- One natural sub-module, timer_prescaler: a parameterised mod-N counter (parameter N, ports clk, rst, wrap).
  - wrap is asserted combinationally when cnt == N-1.
  - timer instantiates it with N=HALF_PERIOD and toggles led on wrap.

Test Plan:
- CLOCK_FREQ=100, BLINK_FREQ=2, 10 ns clk, rst held for 2 edges then released -> led=0 through reset. led rises on the 25th edge after release, falls on the 50th, rises on the 75th, falls on the 100th.
- Same configuration, measure over 200 cycles -> every high and every low phase is exactly 25 cycles; 4 full periods of 50 cycles.
- Reassert rst for 1 cycle at post-release edge 37, while led=1 -> led=0 on that edge. The next rise comes 25 edges after the second release.
- CLOCK_FREQ=4, BLINK_FREQ=2 (HALF_PERIOD=1) -> led toggles every cycle after reset: 0,1,0,1.
- CLOCK_FREQ=101, BLINK_FREQ=2 (truncates to 25) -> timing identical to the first scenario.
- TIMER_TICK_EN defined, configuration from the first scenario -> tick is a single-cycle pulse coincident with each led edge (25, 50, 75, 100), 0 elsewhere and during reset.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and elaboration-time helpers for the LED blink timer.
//   DEFAULT_CLOCK_FREQ : default system clock frequency in Hz
//   half_period()      : clock cycles per led phase (truncating division)
//   cnt_width()        : counter width able to hold 0..n-1, never below 1
package timer_pkg;

    localparam int unsigned DEFAULT_CLOCK_FREQ = 100_000_000;

    // A zero blink_freq is illegal and is reported by the top; return 0 here so
    // elaboration reaches that check instead of dividing by zero.
    function automatic int unsigned half_period(input int unsigned clock_freq,
                                                input int unsigned blink_freq);
        if (blink_freq == 0) begin
            return 0;
        end
        return clock_freq / (2 * blink_freq);
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: free-running mod-N counter.
//   clk  : clock, rising-edge active
//   rst  : synchronous active-high reset, clears the count
//   wrap : high while the count sits at N-1 (combinational from the count register)
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    output logic wrap
);

    localparam int unsigned CNT_W = cnt_width(N);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Full-width compare so the count can never run past N-1.
    assign wrap = (cnt_q == LAST_CNT);

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (wrap) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer.sv
// timer: free-running LED blink timer, divides clk down to a BLINK_FREQ Hz square wave.
//   clk  : sole clock, rising-edge active
//   rst  : synchronous active-high reset
//   led  : registered 50% duty square wave, period 2*HALF_PERIOD clk cycles
//   tick : (only with TIMER_TICK_EN defined) registered one-cycle pulse aligned
//          with every new led value
// Optional feature macro: TIMER_TICK_EN.
module timer
    import timer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = DEFAULT_CLOCK_FREQ,
    parameter int unsigned BLINK_FREQ = 1
) (
    input  logic clk,
    input  logic rst,
`ifdef TIMER_TICK_EN
    output logic tick,
`endif
    output logic led
);

    localparam int unsigned HALF_PERIOD = half_period(CLOCK_FREQ, BLINK_FREQ);

    if (BLINK_FREQ == 0 || CLOCK_FREQ == 0 || CLOCK_FREQ < 2 * BLINK_FREQ) begin : gen_param_err
        $error("timer: need CLOCK_FREQ > 0, BLINK_FREQ > 0 and CLOCK_FREQ >= 2*BLINK_FREQ");
    end

    logic wrap;
    logic led_q;

    timer_prescaler #(
        .N (HALF_PERIOD)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .wrap (wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            led_q <= 1'b0;
        end else if (wrap) begin
            led_q <= ~led_q;
        end
    end

    assign led = led_q;

`ifdef TIMER_TICK_EN
    logic tick_q;

    // Registered alongside led so the pulse lines up with the new led value.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= wrap;
        end
    end

    assign tick = tick_q;
`endif

endmodule

// File: tb/tb_timer.sv
module tb_timer;

    logic clk = 1'b0;
    logic rst;
    logic led_a;
    logic led_b;
    logic led_c;
`ifdef TIMER_TICK_EN
    logic tick_a;
    logic tick_b;
    logic tick_c;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // a: HALF_PERIOD 25, b: HALF_PERIOD 1, c: 101/4 truncates to 25
    timer #(.CLOCK_FREQ(100), .BLINK_FREQ(2)) u_a (
        .clk  (clk),
        .rst  (rst),
`ifdef TIMER_TICK_EN
        .tick (tick_a),
`endif
        .led  (led_a)
    );

    timer #(.CLOCK_FREQ(4), .BLINK_FREQ(2)) u_b (
        .clk  (clk),
        .rst  (rst),
`ifdef TIMER_TICK_EN
        .tick (tick_b),
`endif
        .led  (led_b)
    );

    timer #(.CLOCK_FREQ(101), .BLINK_FREQ(2)) u_c (
        .clk  (clk),
        .rst  (rst),
`ifdef TIMER_TICK_EN
        .tick (tick_c),
`endif
        .led  (led_c)
    );

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (led_a !== 1'b0 || led_b !== 1'b0 || led_c !== 1'b0) begin
                failures++;
                $display("FAIL reset_led edge=%0d got a=%b b=%b c=%b expected 0 0 0",
                         i, led_a, led_b, led_c);
            end
`ifdef TIMER_TICK_EN
            checks++;
            if (tick_a !== 1'b0 || tick_b !== 1'b0 || tick_c !== 1'b0) begin
                failures++;
                $display("FAIL reset_tick edge=%0d got a=%b b=%b c=%b expected 0 0 0",
                         i, tick_a, tick_b, tick_c);
            end
`endif
        end
    endtask

    task automatic test_blink();
        logic exp_a;
        logic exp_b;
        do_reset(2);
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            exp_a = ((k / 25) % 2) == 1;
            exp_b = (k % 2) == 1;
            checks++;
            if (led_a !== exp_a) begin
                failures++;
                $display("FAIL blink_hp25 edge=%0d got %b expected %b", k, led_a, exp_a);
            end
            checks++;
            if (led_b !== exp_b) begin
                failures++;
                $display("FAIL blink_hp1 edge=%0d got %b expected %b", k, led_b, exp_b);
            end
            checks++;
            if (led_c !== exp_a) begin
                failures++;
                $display("FAIL blink_trunc edge=%0d got %b expected %b", k, led_c, exp_a);
            end
`ifdef TIMER_TICK_EN
            checks++;
            if (tick_a !== ((k % 25) == 0)) begin
                failures++;
                $display("FAIL tick_hp25 edge=%0d got %b expected %b", k, tick_a, (k % 25) == 0);
            end
            checks++;
            if (tick_b !== 1'b1) begin
                failures++;
                $display("FAIL tick_hp1 edge=%0d got %b expected 1", k, tick_b);
            end
`endif
        end
    endtask

    task automatic test_period();
        logic prev;
        int   last;
        int   toggles;
        do_reset(2);
        rst     = 1'b0;
        prev    = 1'b0;
        last    = 0;
        toggles = 0;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk);
            #1;
            if (led_a !== prev) begin
                toggles++;
                checks++;
                if (k - last != 25) begin
                    failures++;
                    $display("FAIL phase_len edge=%0d got %0d expected 25", k, k - last);
                end
                last = k;
                prev = led_a;
            end
        end
        checks++;
        if (toggles != 8) begin
            failures++;
            $display("FAIL toggle_count got %0d expected 8", toggles);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2);
        rst = 1'b0;
        repeat (36) @(posedge clk);
        #1;
        checks++;
        if (led_a !== 1'b1) begin
            failures++;
            $display("FAIL mid_pre_reset edge=36 got %b expected 1", led_a);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (led_a !== 1'b0 || led_c !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset edge=37 got a=%b c=%b expected 0 0", led_a, led_c);
        end
        rst = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (led_a !== (k >= 25)) begin
                failures++;
                $display("FAIL mid_restart edge=%0d got %b expected %b", k, led_a, k >= 25);
            end
`ifdef TIMER_TICK_EN
            checks++;
            if (tick_a !== (k == 25)) begin
                failures++;
                $display("FAIL mid_tick edge=%0d got %b expected %b", k, tick_a, k == 25);
            end
`endif
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_blink();
        test_period();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
